// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_unit_pkg;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;

  localparam logic [PC_W-1:0]    PC_STEP   = 64'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'b0;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  // One fetch-buffer entry: the PC the request was issued for and the returned word.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - control, instruction-memory and IF/ID signals of the fetch unit
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic               stall;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr_out;
  logic [PC_W-1:0]    pc_out;

  // The fetch unit itself.
  modport master (
    input  stall, redirect, redirect_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output imem_req_valid, imem_addr,
    output instr_valid, instr_out, pc_out
  );

  // Pipeline control, instruction memory and the IF/ID stage around it.
  modport slave (
    output stall, redirect, redirect_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  imem_req_valid, imem_addr,
    input  instr_valid, instr_out, pc_out
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small circular FIFO with flush, used for the fetch buffer and PC queue
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;
  logic             do_push;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_CNT) || do_pop);
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - credit-based instruction fetch with in-order buffer and redirect flush
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = 64'h0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam int CNT_W   = $clog2(BUF_DEPTH + 1);
  localparam int ENTRY_W = $bits(fetch_entry_t);
  localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(BUF_DEPTH);

  fetch_state_t     state;
  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] buf_count;
  logic [CNT_W-1:0] pcq_count;
  logic [PC_W-1:0]  pcq_head;
  fetch_entry_t     buf_in;
  fetch_entry_t     buf_head;

  logic             credit_ok;
  logic             req_valid;
  logic             req_fire;
  logic             rsp_live;
  logic             rsp_keep;
  logic             head_valid;
  logic             pop_head;
  logic [CNT_W-1:0] out_after_rsp;
  logic [CNT_W-1:0] drop_after;

  // A request may only go out while in-flight plus buffered entries leave room,
  // so a returning response always finds a free buffer slot.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, buf_count}) < CREDIT_MAX;
  assign req_valid = (state == RUN) && credit_ok && !bus.redirect;
  assign req_fire  = req_valid && bus.imem_req_ready;

  // Responses only count against real requests; anything seen while booting or
  // with no request in flight is stale memory traffic and ignored.
  assign rsp_live = bus.imem_rsp_valid && (state != BOOT) && (pcq_count != '0);
  assign rsp_keep = rsp_live && (state == RUN) && !bus.redirect;

  assign head_valid = (buf_count != '0);
  assign pop_head   = head_valid && !bus.stall && !bus.redirect;

  assign out_after_rsp = outstanding - CNT_W'(rsp_live);
  assign drop_after    = drop_cnt - CNT_W'(rsp_live);
  assign buf_in        = '{pc: pcq_head, instr: bus.imem_rsp_data};

  // PCs of in-flight requests, consumed by every response, kept or dropped.
  fetch_fifo #(
    .WIDTH (PC_W),
    .DEPTH (BUF_DEPTH)
  ) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (pc),
    .pop       (rsp_live),
    .flush     (1'b0),
    .head      (pcq_head),
    .count     (pcq_count)
  );

  // Fetched instructions waiting for IF/ID; a redirect discards them all.
  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_keep),
    .push_data (buf_in),
    .pop       (pop_head),
    .flush     (bus.redirect),
    .head      (buf_head),
    .count     (buf_count)
  );

  // Fetch sequencing: PC advance, redirect handling and draining of stale responses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
          if (bus.redirect) pc <= bus.redirect_pc;
        end
        RUN: begin
          if (bus.redirect) begin
            pc       <= bus.redirect_pc;
            drop_cnt <= out_after_rsp;
            state    <= (out_after_rsp != '0) ? FLUSH : RUN;
          end else if (req_fire) begin
            pc <= pc + PC_STEP;
          end
        end
        FLUSH: begin
          if (bus.redirect) pc <= bus.redirect_pc;
          drop_cnt <= drop_after;
          if (drop_after == '0) state <= RUN;
        end
        default: state <= BOOT;
      endcase
    end
  end

  // In-flight request count; no requests are issued in FLUSH, so it tracks drop_cnt there.
  always_ff @(posedge clk) begin
    if (!rst) begin
      outstanding <= '0;
    end else begin
      outstanding <= out_after_rsp + CNT_W'(req_fire);
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = req_valid ? pc : '0;
  assign bus.instr_valid    = head_valid;
  assign bus.instr_out      = head_valid ? buf_head.instr : NOP_INSTR;
  assign bus.pc_out         = head_valid ? buf_head.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [63:0] RST_PC = 64'h1000;
  localparam int          DEPTH  = 2;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mem_req_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_req_t    mem_q[$];
  logic [95:0] exp_q[$];
  logic [63:0] model_pc;
  logic [63:0] p0;
  int          cyc;
  int          lat;
  int          n_checks;
  int          n_pass;
  int          n_fail;
  int          n;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h5A00_0013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic        rst_pre;
    logic        acc;
    logic        consumed;
    logic        redir;
    logic [63:0] req_addr;
    logic [63:0] redir_pc;
    #1;
    rst_pre  = rst;
    acc      = bus.imem_req_valid && bus.imem_req_ready;
    consumed = bus.instr_valid && !bus.stall && !bus.redirect;
    redir    = bus.redirect;
    req_addr = bus.imem_addr;
    redir_pc = bus.redirect_pc;
    if (rst_pre) begin
      if (redir) chk("no_req_on_redirect", 64'(bus.imem_req_valid), 0);
      if (bus.imem_req_valid) chk("imem_addr", bus.imem_addr, model_pc);
      if (bus.instr_valid) begin
        if (exp_q.size() == 0) chk("unexpected_instr_valid", 64'(bus.instr_valid), 0);
        else begin
          chk("head_pc", bus.pc_out, exp_q[0][95:32]);
          chk("head_instr", 64'(bus.instr_out), 64'(exp_q[0][31:0]));
        end
      end else begin
        chk("idle_instr", 64'(bus.instr_out), 0);
        chk("idle_pc", bus.pc_out, 0);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_pre) begin
      mem_q.delete();
      exp_q.delete();
      model_pc = RST_PC;
    end else begin
      if (redir) begin
        exp_q.delete();
        model_pc = redir_pc;
      end else begin
        if (consumed && exp_q.size() > 0) void'(exp_q.pop_front());
        if (acc) begin
          exp_q.push_back({model_pc, mem_word(model_pc)});
          model_pc = model_pc + 64'd4;
        end
      end
      if (acc) mem_q.push_back('{addr: req_addr, due: cyc + lat - 1});
      chk("credit_bound", 64'(exp_q.size() > DEPTH), 0);
    end
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_valid"}, 64'(bus.imem_req_valid), 0);
    chk({tag, "_addr"}, bus.imem_addr, 0);
    chk({tag, "_instr_valid"}, 64'(bus.instr_valid), 0);
    chk({tag, "_instr_out"}, 64'(bus.instr_out), 0);
    chk({tag, "_pc_out"}, bus.pc_out, 0);
  endtask

  task automatic wait_valid(input string tag, input logic [63:0] exp_pc);
    n = 0;
    while (!bus.instr_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 64'(bus.instr_valid), 1);
    chk({tag, "_pc"}, bus.pc_out, exp_pc);
    chk({tag, "_instr"}, 64'(bus.instr_out), 64'(mem_word(exp_pc)));
  endtask

  initial begin
    n_checks = 0; n_pass = 0; n_fail = 0; cyc = 0; lat = 1;
    model_pc = RST_PC;
    rst = 1'b0;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 64'h0;
    bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;

    repeat (3) tick();
    chk_all_zero("reset");

    // First instruction latency after reset release, then a streaming run.
    rst = 1'b1;
    n = 0;
    while (!bus.instr_valid && n < 20) begin
      tick();
      n++;
    end
    chk("first_valid_latency", 64'(n), 3);
    chk("first_pc", bus.pc_out, RST_PC);
    repeat (12) tick();

    // Stall hold: head must stay put and credit must not be exceeded.
    bus.stall = 1'b1;
    repeat (5) tick();
    bus.stall = 1'b0;
    repeat (12) tick();

    // Memory not ready: address and PC held, buffer drains to zeros.
    p0 = model_pc;
    bus.imem_req_ready = 1'b0;
    repeat (4) tick();
    chk("ready_low_req_valid", 64'(bus.imem_req_valid), 1);
    chk("ready_low_addr_held", bus.imem_addr, p0);
    chk("ready_low_drained_valid", 64'(bus.instr_valid), 0);
    chk("ready_low_drained_instr", 64'(bus.instr_out), 0);
    bus.imem_req_ready = 1'b1;
    repeat (8) tick();

    // Redirect with two requests in flight: both responses must be dropped.
    lat = 3;
    n = 0;
    while (!(mem_q.size() == 2 && !bus.imem_rsp_valid) && n < 40) begin
      tick();
      n++;
    end
    chk("redir_setup_inflight", 64'(mem_q.size()), 2);
    bus.redirect = 1'b1; bus.redirect_pc = 64'h2000;
    tick();
    bus.redirect = 1'b0;
    chk("redir_kills_valid", 64'(bus.instr_valid), 0);
    chk("redir_drop_cnt", 64'(dut.drop_cnt), 2);
    wait_valid("redir_first", 64'h2000);
    lat = 1;
    repeat (10) tick();

    // Redirect + stall + response in the same cycle.
    lat = 2;
    n = 0;
    while (!(bus.imem_rsp_valid && mem_q.size() == 1) && n < 40) begin
      tick();
      n++;
    end
    chk("combo_setup_rsp", 64'(bus.imem_rsp_valid), 1);
    bus.redirect = 1'b1; bus.stall = 1'b1; bus.redirect_pc = 64'h3000;
    tick();
    bus.redirect = 1'b0; bus.stall = 1'b0;
    chk("combo_drop_cnt", 64'(dut.drop_cnt), 1);
    chk("combo_valid", 64'(bus.instr_valid), 0);
    wait_valid("combo_first", 64'h3000);
    lat = 1;
    repeat (6) tick();

    // Reset in the middle of traffic, with a stale response right after release.
    bus.stall = 1'b1;
    n = 0;
    while (!(exp_q.size() == DEPTH && bus.instr_valid) && n < 20) begin
      tick();
      n++;
    end
    chk("midrst_setup", 64'(exp_q.size()), DEPTH);
    rst = 1'b0;
    tick();
    chk_all_zero("midrst");
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    wait_valid("midrst_restart", RST_PC);
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
